// File: rtl/axi2mem_pkg.sv
// Shared types for the axi2mem TCDM front end.
// Holds the owner encoding used by the command arbiter and the TCDM lane count.
package axi2mem_pkg;

  localparam int unsigned AXI2MEM_LANES = 2;

  typedef enum logic {
    OWN_RD = 1'b0,
    OWN_WR = 1'b1
  } axi2mem_owner_e;

endpackage

// File: rtl/axi2mem_tcdm_cmd_arbiter.sv
// Shares the dual-lane TCDM command queue between the axi2mem read and write channels.
// The command mux has no latency. A registered owner FSM picks the channel using burst-aware round-robin with optional preemption.
module axi2mem_tcdm_cmd_arbiter
  import axi2mem_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      rd_pend_i,
  input  logic [AXI2MEM_LANES-1:0]                  rd_trans_req_i,
  input  logic [AXI2MEM_LANES-1:0][ID_WIDTH-1:0]    rd_trans_id_i,
  input  logic [AXI2MEM_LANES-1:0][ADDR_WIDTH-1:0]  rd_trans_add_i,
  input  logic [AXI2MEM_LANES-1:0]                  rd_trans_last_i,
  output logic [AXI2MEM_LANES-1:0]                  rd_trans_gnt_o,
  input  logic                                      wr_pend_i,
  input  logic [AXI2MEM_LANES-1:0]                  wr_trans_req_i,
  input  logic [AXI2MEM_LANES-1:0][ID_WIDTH-1:0]    wr_trans_id_i,
  input  logic [AXI2MEM_LANES-1:0][ADDR_WIDTH-1:0]  wr_trans_add_i,
  input  logic [AXI2MEM_LANES-1:0]                  wr_trans_last_i,
  output logic [AXI2MEM_LANES-1:0]                  wr_trans_gnt_o,
  output logic [AXI2MEM_LANES-1:0]                  cmd_req_o,
  output logic [AXI2MEM_LANES-1:0][ID_WIDTH-1:0]    cmd_id_o,
  output logic [AXI2MEM_LANES-1:0][ADDR_WIDTH-1:0]  cmd_add_o,
  output logic [AXI2MEM_LANES-1:0]                  cmd_last_o,
  output logic [AXI2MEM_LANES-1:0]                  cmd_wen_o,
  input  logic [AXI2MEM_LANES-1:0]                  cmd_gnt_i,
  output logic                                      owner_o
);

  localparam logic [7:0] PREEMPT_AT = 8'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);

  axi2mem_owner_e owner_q;
  logic [1:0]     busy_q;
  logic [7:0]     beat_cnt_q;

  logic                    own_idx;
  logic                    oth_idx;
  logic [AXI2MEM_LANES-1:0] own_req;
  logic [AXI2MEM_LANES-1:0] own_last;
  logic [1:0]              want;
  logic                    hs;
  logic                    burst_last;
  logic                    hs_last;
  logic                    preempt;
  logic                    do_switch;

  assign own_idx = owner_q;
  assign oth_idx = ~own_idx;

  always_comb begin
    own_req   = rd_trans_req_i;
    own_last  = rd_trans_last_i;
    cmd_id_o  = rd_trans_id_i;
    cmd_add_o = rd_trans_add_i;
    if (owner_q == OWN_WR) begin
      own_req   = wr_trans_req_i;
      own_last  = wr_trans_last_i;
      cmd_id_o  = wr_trans_id_i;
      cmd_add_o = wr_trans_add_i;
    end
  end

  assign cmd_req_o  = own_req;
  assign cmd_last_o = own_last;
  assign cmd_wen_o  = {AXI2MEM_LANES{owner_q == OWN_WR}};
  assign owner_o    = owner_q;

  // Grants only look at registered owner and the queue ready, never at the requests.
  assign rd_trans_gnt_o = (owner_q == OWN_RD) ? cmd_gnt_i : '0;
  assign wr_trans_gnt_o = (owner_q == OWN_WR) ? cmd_gnt_i : '0;

  // The channel drives last identically on both lanes, so any lane marks the burst end.
  assign hs         = (own_req == '1) && (cmd_gnt_i == '1);
  assign burst_last = |own_last;
  assign hs_last    = hs && burst_last;
  assign want       = {wr_pend_i | busy_q[1], rd_pend_i | busy_q[0]};
  assign preempt    = (MAX_BEATS != 0) && hs && (beat_cnt_q == PREEMPT_AT);
  assign do_switch  = want[oth_idx] && (hs_last || !want[own_idx] || preempt);

  // A preempted owner keeps its busy flag so its burst resumes when ownership returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q    <= OWN_RD;
      busy_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (hs) begin
        busy_q[own_idx] <= ~burst_last;
      end
      if (do_switch || hs_last) begin
        beat_cnt_q <= '0;
      end else if (hs && (beat_cnt_q != 8'hFF)) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end
      if (do_switch) begin
        owner_q <= (owner_q == OWN_RD) ? OWN_WR : OWN_RD;
      end
    end
  end

`ifndef SYNTHESIS
  a_non_owner_no_gnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (owner_q == OWN_RD) ? (wr_trans_gnt_o == '0) : (rd_trans_gnt_o == '0));
  a_wen_is_owner : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cmd_wen_o == {AXI2MEM_LANES{owner_q == OWN_WR}});
`endif

endmodule

// File: tb/tb_axi2mem_tcdm_cmd_arbiter.sv
// Self-checking bench for axi2mem_tcdm_cmd_arbiter: channel BFMs plus a reference model feed a scoreboard queue.
// A negedge monitor pops and compares expected outputs.
module tb_axi2mem_tcdm_cmd_arbiter;

  localparam int ID_W   = 6;
  localparam int ADDR_W = 32;
  localparam int MAXB   = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic                    rd_pend_i, wr_pend_i;
  logic [1:0]              rd_trans_req_i, wr_trans_req_i;
  logic [1:0][ID_W-1:0]    rd_trans_id_i, wr_trans_id_i;
  logic [1:0][ADDR_W-1:0]  rd_trans_add_i, wr_trans_add_i;
  logic [1:0]              rd_trans_last_i, wr_trans_last_i;
  logic [1:0]              rd_trans_gnt_o, wr_trans_gnt_o;
  logic [1:0]              cmd_req_o, cmd_last_o, cmd_wen_o, cmd_gnt_i;
  logic [1:0][ID_W-1:0]    cmd_id_o;
  logic [1:0][ADDR_W-1:0]  cmd_add_o;
  logic                    owner_o;

  axi2mem_tcdm_cmd_arbiter #(
    .ID_WIDTH  (ID_W),
    .ADDR_WIDTH(ADDR_W),
    .MAX_BEATS (MAXB)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rd_pend_i      (rd_pend_i),
    .rd_trans_req_i (rd_trans_req_i),
    .rd_trans_id_i  (rd_trans_id_i),
    .rd_trans_add_i (rd_trans_add_i),
    .rd_trans_last_i(rd_trans_last_i),
    .rd_trans_gnt_o (rd_trans_gnt_o),
    .wr_pend_i      (wr_pend_i),
    .wr_trans_req_i (wr_trans_req_i),
    .wr_trans_id_i  (wr_trans_id_i),
    .wr_trans_add_i (wr_trans_add_i),
    .wr_trans_last_i(wr_trans_last_i),
    .wr_trans_gnt_o (wr_trans_gnt_o),
    .cmd_req_o      (cmd_req_o),
    .cmd_id_o       (cmd_id_o),
    .cmd_add_o      (cmd_add_o),
    .cmd_last_o     (cmd_last_o),
    .cmd_wen_o      (cmd_wen_o),
    .cmd_gnt_i      (cmd_gnt_i),
    .owner_o        (owner_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic                   owner;
    logic [1:0]             rd_gnt;
    logic [1:0]             wr_gnt;
    logic [1:0]             req;
    logic [1:0]             last;
    logic [1:0]             wen;
    logic [1:0][ID_W-1:0]   id;
    logic [1:0][ADDR_W-1:0] add;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] obsRdAddr[$];
  int          nVectors     = 0;
  int          nMiscompares = 0;
  bit          checkingOn   = 0;
  bit          recordRd     = 0;

  // Reference model state (0 = rd, 1 = wr) and per-channel burst BFMs.
  int          mOwner;
  bit [1:0]    mBusy;
  int          mBeats;
  int          left[2];
  logic [31:0] nextAddr[2];
  logic [5:0]  nextId[2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic startBurst(input int ch, input int beats, input logic [31:0] addr);
    left[ch]     = beats;
    nextAddr[ch] = addr;
  endtask

  task automatic resetModel();
    mOwner = 0;
    mBusy  = 2'b00;
    mBeats = 0;
    for (int c = 0; c < 2; c++) begin
      left[c]     = 0;
      nextAddr[c] = '0;
      nextId[c]   = '0;
    end
  endtask

  // Drives one cycle from the BFMs, pushes the expected outputs and advances the model.
  task automatic applyStimulus(input logic [1:0] gnt, input bit rdExtra, input bit wrExtra,
                               input logic [1:0] rdMask, input logic [1:0] wrMask);
    logic [1:0] req[2];
    logic [1:0] lst[2];
    bit         pend[2];
    exp_t       e;
    int         own, oth;
    bit         hs, isLast, wantOwn, wantOth, preempt, sw;
    req[0]  = (left[0] > 0) ? rdMask : 2'b00;
    req[1]  = (left[1] > 0) ? wrMask : 2'b00;
    lst[0]  = (left[0] == 1) ? 2'b11 : 2'b00;
    lst[1]  = (left[1] == 1) ? 2'b11 : 2'b00;
    pend[0] = (left[0] > 0) || rdExtra;
    pend[1] = (left[1] > 0) || wrExtra;
    rd_pend_i       = pend[0];
    rd_trans_req_i  = req[0];
    rd_trans_id_i   = {nextId[0], nextId[0]};
    rd_trans_add_i  = {nextAddr[0] + 32'd4, nextAddr[0]};
    rd_trans_last_i = lst[0];
    wr_pend_i       = pend[1];
    wr_trans_req_i  = req[1];
    wr_trans_id_i   = {nextId[1], nextId[1]};
    wr_trans_add_i  = {nextAddr[1] + 32'd4, nextAddr[1]};
    wr_trans_last_i = lst[1];
    cmd_gnt_i       = gnt;

    own      = mOwner;
    oth      = 1 - own;
    e.owner  = (own == 1);
    e.rd_gnt = (own == 0) ? gnt : 2'b00;
    e.wr_gnt = (own == 1) ? gnt : 2'b00;
    e.req    = req[own];
    e.last   = lst[own];
    e.wen    = (own == 1) ? 2'b11 : 2'b00;
    e.id     = (own == 1) ? wr_trans_id_i : rd_trans_id_i;
    e.add    = (own == 1) ? wr_trans_add_i : rd_trans_add_i;
    sbq.push_back(e);

    hs      = (req[own] == 2'b11) && (gnt == 2'b11);
    isLast  = hs && (left[own] == 1);
    wantOwn = pend[own] || mBusy[own];
    wantOth = pend[oth] || mBusy[oth];
    preempt = (MAXB != 0) && hs && (mBeats == MAXB - 1);
    sw      = wantOth && (isLast || !wantOwn || preempt);
    if (hs) begin
      left[own]--;
      nextAddr[own] += 32'd8;
      nextId[own]   += 6'd1;
      mBusy[own]     = !isLast;
    end
    if (sw || isLast) mBeats = 0;
    else if (hs && mBeats < 255) mBeats++;
    if (sw) mOwner = oth;
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    checkingOn = 0;
    rst_ni     = 1'b0;
    rd_pend_i = 1'b0; rd_trans_req_i = '0; rd_trans_id_i = '0; rd_trans_add_i = '0; rd_trans_last_i = '0;
    wr_pend_i = 1'b0; wr_trans_req_i = '0; wr_trans_id_i = '0; wr_trans_add_i = '0; wr_trans_last_i = '0;
    cmd_gnt_i = 2'b11;
    sbq.delete();
    resetModel();
    @(posedge clk_i);
    #1;
    rst_ni     = 1'b1;
    checkingOn = 1;
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (checkingOn) begin
      if (sbq.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL sb_underflow: got empty queue, required an entry at %0t", $time);
      end else begin
        e = sbq.pop_front();
        checkOutput("owner_o", 64'(owner_o), 64'(e.owner));
        checkOutput("rd_trans_gnt_o", 64'(rd_trans_gnt_o), 64'(e.rd_gnt));
        checkOutput("wr_trans_gnt_o", 64'(wr_trans_gnt_o), 64'(e.wr_gnt));
        checkOutput("cmd_req_o", 64'(cmd_req_o), 64'(e.req));
        checkOutput("cmd_wen_o", 64'(cmd_wen_o), 64'(e.wen));
        if (cmd_req_o != 2'b00) begin
          checkOutput("cmd_id_o", 64'(cmd_id_o), 64'(e.id));
          checkOutput("cmd_add_o", 64'(cmd_add_o), 64'(e.add));
          checkOutput("cmd_last_o", 64'(cmd_last_o), 64'(e.last));
        end
        if (recordRd && cmd_wen_o == 2'b00 && cmd_req_o == 2'b11 && cmd_gnt_i == 2'b11)
          obsRdAddr.push_back(cmd_add_o[0]);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [1:0] g, rm, wm;
    doReset();

    // Reset release with only wr pending: ownership moves to wr after one cycle.
    checkOutput("t0_reset_owner", 64'(owner_o), 64'd0);
    checkOutput("t0_reset_wr_gnt", 64'(wr_trans_gnt_o), 64'd0);
    startBurst(1, 1, 32'h0000_0100);
    applyStimulus(2'b11, 0, 1, 2'b11, 2'b11);
    checkOutput("t1_owner_cycle1", 64'(owner_o), 64'd1);
    checkOutput("t1_wen", 64'(cmd_wen_o), 64'd3);
    applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);
    applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);

    // Rd burst of 4 with wr arriving at beat 2: rd finishes, wr takes over after the last beat.
    doReset();
    startBurst(0, 4, 32'h0000_0200);
    applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);
    applyStimulus(2'b11, 0, 1, 2'b11, 2'b11);
    applyStimulus(2'b11, 0, 1, 2'b11, 2'b11);
    checkOutput("t2_owner_hold", 64'(owner_o), 64'd0);
    applyStimulus(2'b11, 0, 1, 2'b11, 2'b11);
    checkOutput("t2_owner_after_last", 64'(owner_o), 64'd1);
    applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);

    // Long rd burst preempted every MAXB beats by a constantly pending wr channel.
    doReset();
    obsRdAddr.delete();
    recordRd = 1;
    startBurst(0, 16, 32'h0000_1000);
    for (int cyc = 0; cyc < 300 && left[0] > 0; cyc++) begin
      if (left[1] == 0) startBurst(1, 2, 32'h0000_8000);
      applyStimulus(2'b11, 0, 1, 2'b11, 2'b11);
    end
    recordRd = 0;
    if (left[0] > 0) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL t3_timeout: rd beats left %0d, required 0", left[0]);
    end
    checkOutput("t3_rd_count", 64'(obsRdAddr.size()), 64'd16);
    for (int i = 0; i < obsRdAddr.size() && i < 16; i++)
      checkOutput($sformatf("t3_rd_addr%0d", i), 64'(obsRdAddr[i]), 64'(32'h0000_1000 + 32'(8 * i)));

    // Partial grant stalls a wr burst without changing state.
    doReset();
    startBurst(1, 4, 32'h0000_2000);
    applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);
    applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, 0, 0, 2'b11, 2'b11);
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);

    // Non-owner rd requests while wr owns but idle are ignored.
    doReset();
    applyStimulus(2'b11, 0, 1, 2'b11, 2'b11);
    startBurst(0, 2, 32'h0000_3000);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 0, 1, 2'b11, 2'b11);
    for (int i = 0; i < 5; i++) applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);

    // Asynchronous reset in the middle of a wr burst.
    doReset();
    startBurst(1, 6, 32'h0000_4000);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);
    checkingOn = 0;
    sbq.delete();
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_owner", 64'(owner_o), 64'd0);
    checkOutput("t6_wr_gnt", 64'(wr_trans_gnt_o), 64'd0);
    checkOutput("t6_rd_gnt", 64'(rd_trans_gnt_o), 64'd3);
    checkOutput("t6_wen", 64'(cmd_wen_o), 64'd0);
    checkOutput("t6_cmd_req", 64'(cmd_req_o), 64'd0);
    resetModel();
    @(posedge clk_i);
    #1;
    rst_ni     = 1'b1;
    checkingOn = 1;
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 0, 0, 2'b11, 2'b11);

    // Randomized traffic against the reference model.
    doReset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < 2; c++)
        if (left[c] == 0 && $urandom_range(0, 2) == 0)
          startBurst(c, $urandom_range(1, 8), $urandom & 32'hFFFF_FFF8);
      g  = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      rm = ($urandom_range(0, 4) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      wm = ($urandom_range(0, 4) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      applyStimulus(g, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, rm, wm);
    end

    checkingOn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
